// File: rtl/wb_ecall_if.sv
// Syscall service channel: request with argument snapshot, then a single-beat response.
interface wb_ecall_if #(
  parameter int XLEN  = 64,
  parameter int NARGS = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [NARGS*XLEN-1:0] req_args;
  logic                  resp_valid;
  logic [XLEN-1:0]       resp_data;

  modport master (
    output req_valid, req_args,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_args,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/wb_ecall_ctrl.sv
// Writeback stage: result selection, register-file write gating and an ecall engine
// that stalls the pipeline while a syscall is serviced over the svc channel.
module wb_ecall_ctrl #(
  parameter int XLEN    = 64,
  parameter int NARGS   = 8,
  parameter int TIMEOUT = 1024,
  parameter int REG_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_ecall,
  input  logic [REG_W-1:0]      rd_in,
  input  logic                  en_rd_in,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [NARGS*XLEN-1:0] args,
  wb_ecall_if.master            svc,
  output logic [XLEN-1:0]       result,
  output logic [REG_W-1:0]      rd,
  output logic                  en_rd,
  output logic                  stall,
  output logic                  timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state, state_nx;
  logic [NARGS*XLEN-1:0] req_args_q;
  logic [XLEN-1:0]       ecall_result, ecall_result_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  abandon, abandon_nx;
  logic                  timeout_nx;
  logic                  capture;
  logic                  load_result;
  logic                  gone;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_args_q   <= '0;
      ecall_result <= '0;
      cnt          <= '0;
      abandon      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      abandon     <= abandon_nx;
      timeout_err <= timeout_nx;
      if (capture)     req_args_q   <= args;
      if (load_result) ecall_result <= ecall_result_nx;
    end
  end

  // Once the instruction is flushed while a request is in flight, the response
  // must still be drained but its value is dropped and nothing is written.
  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    abandon_nx      = abandon;
    timeout_nx      = 1'b0;
    capture         = 1'b0;
    load_result     = 1'b0;
    ecall_result_nx = svc.resp_data;
    stall           = 1'b0;
    gone            = abandon | ~wb_valid;
    unique case (state)
      IDLE: begin
        abandon_nx = 1'b0;
        if (wb_valid && is_ecall) begin
          stall    = 1'b1;
          capture  = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (svc.req_ready) begin
          state_nx   = WAIT;
          cnt_nx     = '0;
          abandon_nx = ~wb_valid;
        end else if (!wb_valid) begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        stall      = 1'b1;
        cnt_nx     = cnt + CNT_W'(1);
        abandon_nx = gone;
        if (svc.resp_valid || cnt == CNT_LAST) begin
          if (gone) begin
            state_nx = IDLE;
          end else begin
            state_nx    = DONE;
            load_result = 1'b1;
            if (!svc.resp_valid) begin
              ecall_result_nx = '1;
              timeout_nx      = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    if (is_load || is_store) result = mem_result;
    else if (is_ecall)       result = ecall_result;
    else                     result = alu_result;
  end

  assign rd            = rd_in;
  assign en_rd         = wb_valid & en_rd_in & (~is_ecall | (state == DONE));
  assign svc.req_valid = (state == REQ);
  assign svc.req_args  = req_args_q;

endmodule

// File: tb/tb_wb_ecall_ctrl.sv
// Directed bench for wb_ecall_ctrl with a transaction-level reference model.
module tb_wb_ecall_ctrl;
  localparam int XLEN = 64, NARGS = 8, TIMEOUT = 8, REG_W = 5;
  localparam int AW = NARGS * XLEN;

  logic clk, reset, wb_valid, is_load, is_store, is_ecall, en_rd_in;
  logic [REG_W-1:0] rd_in, rd;
  logic [XLEN-1:0]  alu_result, mem_result, result;
  logic [AW-1:0]    args;
  logic en_rd, stall, timeout_err;
  int checks = 0;
  int passes = 0;

  wb_ecall_if #(.XLEN(XLEN), .NARGS(NARGS)) svc ();

  wb_ecall_ctrl #(.XLEN(XLEN), .NARGS(NARGS), .TIMEOUT(TIMEOUT), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .is_load(is_load), .is_store(is_store),
    .is_ecall(is_ecall), .rd_in(rd_in), .en_rd_in(en_rd_in), .alu_result(alu_result),
    .mem_result(mem_result), .args(args), .svc(svc), .result(result), .rd(rd),
    .en_rd(en_rd), .stall(stall), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ecall is "open" from acceptance until it finishes, "sent" once
  // the request is taken; a finished, still-wanted ecall retires on the following cycle.
  bit m_open, m_sent, m_retire, m_err, m_gone;
  int m_waited;
  logic [XLEN-1:0] m_res;
  logic [AW-1:0]   m_args;

  task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    else passes++;
  endtask

  task automatic compare_model();
    logic [XLEN-1:0] er;
    if (!reset) begin
      er = (is_load || is_store) ? mem_result : (is_ecall ? m_res : alu_result);
      chk("m_result", AW'(result), AW'(er));
      chk("m_rd", AW'(rd), AW'(rd_in));
      chk("m_en_rd", AW'(en_rd), AW'(wb_valid & en_rd_in & (!is_ecall | m_retire)));
      chk("m_stall", AW'(stall), AW'(m_open ? 1'b1 : (m_retire ? 1'b0 : (wb_valid & is_ecall))));
      chk("m_req_valid", AW'(svc.req_valid), AW'(m_open & !m_sent));
      chk("m_req_args", svc.req_args, m_args);
      chk("m_timeout_err", AW'(timeout_err), AW'(m_retire & m_err));
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_open = 0; m_sent = 0; m_retire = 0; m_err = 0; m_gone = 0;
      m_waited = 0; m_res = '0; m_args = '0;
    end else if (m_retire) begin
      m_retire = 0; m_err = 0;
    end else if (!m_open) begin
      if (wb_valid && is_ecall) begin
        m_open = 1; m_sent = 0; m_gone = 0; m_args = args;
      end
    end else if (!m_sent) begin
      if (svc.req_ready) begin
        m_sent = 1; m_waited = 0; m_gone = !wb_valid;
      end else if (!wb_valid) begin
        m_open = 0;
      end
    end else begin
      m_gone = m_gone | !wb_valid;
      m_waited++;
      if (svc.resp_valid || m_waited == TIMEOUT) begin
        m_open = 0; m_sent = 0;
        if (!m_gone) begin
          m_retire = 1;
          m_err = !svc.resp_valid;
          m_res = svc.resp_valid ? svc.resp_data : '1;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_instr(input logic v, input logic ld, input logic st, input logic ec,
                           input logic en, input logic [REG_W-1:0] r,
                           input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem);
    wb_valid = v; is_load = ld; is_store = st; is_ecall = ec;
    en_rd_in = en; rd_in = r; alu_result = alu; mem_result = mem;
  endtask

  task automatic set_args(input logic [XLEN-1:0] a0, input logic [XLEN-1:0] a7);
    for (int i = 0; i < NARGS; i++) args[i*XLEN +: XLEN] = XLEN'(64'h0101_0000 + i);
    args[0 +: XLEN] = a0;
    args[(NARGS-1)*XLEN +: XLEN] = a7;
  endtask

  // One ecall from acceptance to retirement; the args bus is scrambled after capture.
  task automatic ecall_seq(input logic [REG_W-1:0] r, input logic [XLEN-1:0] a0,
                           input logic [XLEN-1:0] a7, input int rdy_dly, input int rsp_dly,
                           input logic rsp, input logic [XLEN-1:0] data,
                           output int stalls, output logic [XLEN-1:0] a7_seen,
                           output logic [XLEN-1:0] done_res, output logic done_err,
                           output logic done_en);
    stalls = 0;
    set_instr(1, 0, 0, 1, 1, r, 64'h5555, 64'h6666);
    set_args(a0, a7);
    svc.req_ready = 0; svc.resp_valid = 0; svc.resp_data = '0;
    settle(); stalls += int'(stall); advance();
    args = ~args;
    a7_seen = svc.req_args[(NARGS-1)*XLEN +: XLEN];
    for (int i = 0; i < rdy_dly; i++) begin
      settle(); stalls += int'(stall); advance();
    end
    svc.req_ready = 1;
    settle(); stalls += int'(stall); advance();
    svc.req_ready = 0;
    for (int i = 0; i < rsp_dly; i++) begin
      settle(); stalls += int'(stall); advance();
    end
    if (rsp) begin
      svc.resp_valid = 1; svc.resp_data = data;
      settle(); stalls += int'(stall); advance();
      svc.resp_valid = 0;
    end
    settle();
    stalls += int'(stall);
    done_res = result; done_err = timeout_err; done_en = en_rd;
    advance();
    set_instr(0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  int stalls;
  logic [XLEN-1:0] a7_seen, done_res;
  logic done_err, done_en;

  initial begin
    reset = 1;
    set_instr(0, 0, 0, 0, 0, 0, '0, '0);
    args = '0;
    svc.req_ready = 0; svc.resp_valid = 0; svc.resp_data = '0;
    settle(); advance();
    settle(); advance();
    reset = 0;

    settle();
    chk("rst_stall", AW'(stall), AW'(0));
    chk("rst_req_valid", AW'(svc.req_valid), AW'(0));
    chk("rst_timeout_err", AW'(timeout_err), AW'(0));
    chk("rst_req_args", svc.req_args, '0);
    advance();

    set_instr(1, 0, 0, 0, 1, 5, 64'h1234, 64'h0);
    settle();
    chk("alu_result", AW'(result), AW'(64'h1234));
    chk("alu_en_rd", AW'(en_rd), AW'(1));
    chk("alu_rd", AW'(rd), AW'(5));
    chk("alu_stall", AW'(stall), AW'(0));
    advance();

    set_instr(1, 1, 0, 0, 1, 7, 64'h1, 64'hDEAD);
    settle();
    chk("load_result", AW'(result), AW'(64'hDEAD));
    advance();

    set_instr(0, 0, 0, 0, 1, 7, 64'h9, 64'h0);
    settle();
    chk("bubble_en_rd", AW'(en_rd), AW'(0));
    advance();

    set_instr(1, 0, 1, 0, 0, 2, 64'h3, 64'hBEEF);
    settle();
    chk("store_result", AW'(result), AW'(64'hBEEF));
    advance();

    ecall_seq(10, 1, 64, 0, 0, 1, 13, stalls, a7_seen, done_res, done_err, done_en);
    chk("fast_a7", AW'(a7_seen), AW'(64));
    chk("fast_stalls", AW'(stalls), AW'(3));
    chk("fast_result", AW'(done_res), AW'(13));
    chk("fast_en_rd", AW'(done_en), AW'(1));
    chk("fast_timeout_err", AW'(done_err), AW'(0));

    ecall_seq(11, 2, 93, 5, 1, 1, 64'h77, stalls, a7_seen, done_res, done_err, done_en);
    chk("bp_stalls", AW'(stalls), AW'(9));
    chk("bp_result", AW'(done_res), AW'(64'h77));
    chk("bp_en_rd", AW'(done_en), AW'(1));

    ecall_seq(12, 3, 60, 0, TIMEOUT, 0, 0, stalls, a7_seen, done_res, done_err, done_en);
    chk("to_stalls", AW'(stalls), AW'(10));
    chk("to_result", AW'(done_res), AW'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("to_err", AW'(done_err), AW'(1));
    chk("to_en_rd", AW'(done_en), AW'(1));
    settle();
    chk("to_err_cleared", AW'(timeout_err), AW'(0));
    advance();

    ecall_seq(13, 4, 61, 0, TIMEOUT-1, 1, 64'hABC, stalls, a7_seen, done_res, done_err, done_en);
    chk("to_edge_result", AW'(done_res), AW'(64'hABC));
    chk("to_edge_err", AW'(done_err), AW'(0));

    ecall_seq(14, 5, 62, 0, 0, 1, 21, stalls, a7_seen, done_res, done_err, done_en);
    chk("b2b_first", AW'(done_res), AW'(21));
    ecall_seq(15, 6, 63, 0, 0, 1, 22, stalls, a7_seen, done_res, done_err, done_en);
    chk("b2b_second", AW'(done_res), AW'(22));
    chk("b2b_stalls", AW'(stalls), AW'(3));

    // reset while waiting for the service response
    set_instr(1, 0, 0, 1, 1, 3, 64'h1, 64'h2);
    set_args(7, 5);
    svc.req_ready = 1;
    settle(); advance();
    settle(); advance();
    svc.req_ready = 0;
    settle(); advance();
    reset = 1;
    settle(); advance();
    reset = 0;
    wb_valid = 0;
    svc.resp_valid = 1; svc.resp_data = 64'h99;
    settle();
    chk("rw_stall", AW'(stall), AW'(0));
    chk("rw_req_valid", AW'(svc.req_valid), AW'(0));
    chk("rw_timeout_err", AW'(timeout_err), AW'(0));
    chk("rw_result", AW'(result), AW'(0));
    advance();
    svc.resp_valid = 0;
    settle();
    chk("rw_late_resp", AW'(result), AW'(0));
    advance();

    // flush while the request is still pending
    set_instr(1, 0, 0, 1, 1, 4, 64'h1, 64'h2);
    settle(); advance();
    wb_valid = 0;
    settle();
    chk("fr_req_valid_held", AW'(svc.req_valid), AW'(1));
    advance();
    settle();
    chk("fr_req_valid", AW'(svc.req_valid), AW'(0));
    chk("fr_stall", AW'(stall), AW'(0));
    chk("fr_en_rd", AW'(en_rd), AW'(0));
    advance();

    // flush after the request was accepted: response drained, value dropped
    set_instr(1, 0, 0, 1, 1, 6, 64'h1, 64'h2);
    svc.req_ready = 1;
    settle(); advance();
    settle(); advance();
    svc.req_ready = 0;
    wb_valid = 0;
    settle(); advance();
    settle(); advance();
    svc.resp_valid = 1; svc.resp_data = 64'h42;
    settle(); advance();
    svc.resp_valid = 0;
    settle();
    chk("fw_stall", AW'(stall), AW'(0));
    chk("fw_en_rd", AW'(en_rd), AW'(0));
    chk("fw_timeout_err", AW'(timeout_err), AW'(0));
    chk("fw_result", AW'(result), AW'(0));
    advance();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_ecall_ctrl.md
Name: wb_ecall_ctrl

Overview:
- Parametrised writeback stage with a handshake-based system-call engine.
- Selects the writeback value from the load/store, ecall or ALU path, and gates register-file writes.
- An ecall is issued to an external syscall service over a valid/ready request channel, then the block waits for a response, with a timeout.
- Holds the pipeline (stall) from ecall arrival until the result is ready, then retires the ecall in exactly one cycle.

Parameters:
XLEN, 64, datapath/register width
NARGS, 8, number of argument registers forwarded (arg[NARGS-1] is the syscall number, a7 equivalent)
TIMEOUT, 1024, max WAIT cycles before forced completion (>=2)
REG_W, 5, destination register index width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
wb_valid  input  1  WB stage holds a real instruction (0 = bubble)
is_load  input  1  instruction is load
is_store  input  1  instruction is store
is_ecall  input  1  instruction is ecall
rd_in  input  REG_W  destination register
en_rd_in  input  1  instruction writes rd
alu_result  input  XLEN  ALU path value
mem_result  input  XLEN  memory path value
args  input  NARGS*XLEN  flattened a0..a(NARGS-1); arg i at bits [i*XLEN +: XLEN]
req_valid  output  1  syscall request valid
req_ready  input  1  service accepts request
req_args  output  NARGS*XLEN  latched argument snapshot
resp_valid  input  1  service response valid
resp_data  input  XLEN  syscall return value
result  output  XLEN  writeback data
rd  output  REG_W  writeback register (= rd_in)
en_rd  output  1  register-file write enable
stall  output  1  freeze all stages before and including WB
timeout_err  output  1  one-cycle pulse: ecall completed by timeout

Behaviour:
- Reset is synchronous and active-high on clk; it wins over all other inputs.
- Reset values:
  - state = IDLE
  - req_valid = 0, stall = 0, timeout_err = 0
  - req_args = 0, ecall_result = 0, wait counter = 0
- result mux (combinational):
  - is_load | is_store -> mem_result
  - else is_ecall -> ecall_result register
  - else -> alu_result
- en_rd = wb_valid & en_rd_in & (!is_ecall | state==DONE).
- rd = rd_in always.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - wb_valid & is_ecall -> REQ; capture args into req_args that edge.
  - stall = 1 combinationally in that cycle.
- REQ:
  - req_valid = 1, stall = 1.
  - req_args stable until handshake.
  - req_valid & req_ready -> WAIT; counter cleared.
  - wb_valid == 0 (flush) before handshake -> IDLE; req_valid drops next cycle.
  - resp_valid is ignored in REQ.
- WAIT:
  - req_valid = 0, stall = 1, counter increments each cycle.
  - On resp_valid: ecall_result <= resp_data -> DONE.
  - Counter == TIMEOUT-1 with no resp_valid: ecall_result <= all ones (-1) and timeout_err <= 1 -> DONE.
  - resp_valid on the timeout cycle wins: data is taken, no error.
  - wb_valid dropping in WAIT: stay in WAIT until response or timeout, then go to IDLE (not DONE), result discarded, no write.
- DONE:
  - stall = 0; en_rd per formula; timeout_err high for this cycle only.
  - Next state is IDLE unconditionally. The next instruction is therefore evaluated in IDLE; back-to-back ecalls are each fully serviced.
- Latency: minimum ecall occupancy is 4 cycles (IDLE, REQ, WAIT, DONE) with stall high for 3, when req_ready and resp_valid each arrive on their first possible cycle.
- Non-ecall instructions and bubbles: stall = 0, zero added latency.
- Reset mid-operation: immediate return to IDLE next edge, all outputs at reset values. Any outstanding service response after reset is ignored unless in WAIT.

Test Plan:
- ALU op: wb_valid=1, en_rd_in=1, rd_in=5, alu_result=0x1234 -> result=0x1234, en_rd=1, rd=5, stall=0, same cycle.
- Load: is_load=1, mem_result=0xDEAD, alu_result=0x1 -> result=0xDEAD. Bubble (wb_valid=0, en_rd_in=1) -> en_rd=0.
- Ecall fast path: is_ecall, a7=64, a0=1; req_ready=1 at once; resp_valid next cycle with resp_data=13 -> req_args a7 field = 64, stall high 3 cycles; DONE cycle result=13, en_rd=1, stall=0; timeout_err never set.
- Backpressure: req_ready low 5 cycles -> req_valid held, req_args unchanged, stall held; completion after ready rises.
- Timeout with TIMEOUT=8: no resp_valid -> after 8 WAIT cycles result=0xFFFF_FFFF_FFFF_FFFF, timeout_err pulses 1 cycle, en_rd=1.
- Reset asserted during WAIT -> next cycle state IDLE, stall=0, req_valid=0; a later resp_valid has no effect. Flush in REQ (wb_valid=0) -> IDLE, no write.
